// File: rtl/if_fetch_stage.sv
// if_fetch_stage: owns the PC, drives the imem handshake and loads IF/ID, absorbing
// stalls, flushes, slow memory and redirects that arrive while a fetch is outstanding.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic [1:0]  pc_src,
   input  logic [31:0] pcBr,
   input  logic [31:0] pcJ,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rdy,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc,
   output logic [31:0] if_id_inst,
   output logic [31:0] if_id_pc4,
   output logic        if_id_valid
);
   typedef enum logic {FETCH, HELD} stateT;
   stateT state, stateNext;
   logic [31:0] pcNext, instNext, pc4Next, skidInst, skidPc4, skidInstNext, skidPc4Next;
   logic [31:0] redirPc, redirPcNext, pc4, target;
   logic validNext, redirPend, redirPendNext, redirect;
   assign pc4 = pc + 32'd4;
   assign redirect = !stall && pc_src != 2'b00;
   assign target = pc_src == 2'b01 ? pcBr : pcJ;
   assign imem_addr = pc;
   assign imem_req = !rst && state == FETCH;
   always_comb begin
      stateNext = state;
      pcNext = pc;
      {instNext, pc4Next, validNext} = {if_id_inst, if_id_pc4, if_id_valid};
      {skidInstNext, skidPc4Next} = {skidInst, skidPc4};
      redirPcNext = redirPc;
      redirPendNext = redirPend;
      if (state == FETCH) begin
         if (imem_rdy) begin
            // A redirect that arrived mid-access takes effect once the stale word returns
            if (redirPend) begin
               pcNext = redirPc;
               redirPendNext = 1'b0;
               if (!stall) {instNext, pc4Next, validNext} = {NOP_INST, 32'd0, 1'b0};
            end else if (stall) begin
               {skidInstNext, skidPc4Next} = {imem_rdata, pc4};
               stateNext = HELD;
            end else if (redirect) begin
               {instNext, pc4Next, validNext} = {NOP_INST, 32'd0, 1'b0};
               pcNext = target;
            end else begin
               {instNext, pc4Next, validNext} = {imem_rdata, pc4, 1'b1};
               pcNext = pc4;
            end
         end else if (!stall) begin
            {instNext, pc4Next, validNext} = {NOP_INST, 32'd0, 1'b0};
            if (redirect) begin
               redirPcNext = target;
               redirPendNext = 1'b1;
            end
         end
      end else if (!stall) begin
         stateNext = FETCH;
         if (redirect) begin
            {instNext, pc4Next, validNext} = {NOP_INST, 32'd0, 1'b0};
            pcNext = target;
         end else begin
            {instNext, pc4Next, validNext} = {skidInst, skidPc4, 1'b1};
            pcNext = skidPc4;
         end
      end
      if (flush) {instNext, pc4Next, validNext} = {NOP_INST, 32'd0, 1'b0};
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= FETCH;
         pc <= RESET_PC;
         {if_id_inst, if_id_pc4, if_id_valid} <= {NOP_INST, 32'd0, 1'b0};
         {skidInst, skidPc4} <= 64'd0;
         redirPc <= 32'd0;
         redirPend <= 1'b0;
      end else begin
         state <= stateNext;
         pc <= pcNext;
         {if_id_inst, if_id_pc4, if_id_valid} <= {instNext, pc4Next, validNext};
         {skidInst, skidPc4} <= {skidInstNext, skidPc4Next};
         redirPc <= redirPcNext;
         redirPend <= redirPendNext;
      end
   end
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed scenarios plus a randomized run against a queue-based fetch model.
module tb_if_fetch_stage;
   logic clk = 1'b0, rst = 1'b1, stall = 1'b0, flush = 1'b0, imem_rdy = 1'b0;
   logic [1:0] pc_src = 2'b00;
   logic [31:0] pcBr = 32'd0, pcJ = 32'd0;
   logic imem_req, if_id_valid;
   logic [31:0] imem_addr, imem_rdata, pc, if_id_inst, if_id_pc4;
   int checks = 0, errors = 0;
   logic [31:0] mPc = 32'd0, mInst = 32'd0, mPc4 = 32'd0;
   logic mValid = 1'b0;
   logic [63:0] skidQ[$];
   logic [31:0] pendQ[$];
   logic sawReq, expReq;
   logic [31:0] sawAddr, expAddr;

   if_fetch_stage dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .pc_src(pc_src), .pcBr(pcBr), .pcJ(pcJ),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdy(imem_rdy), .imem_rdata(imem_rdata),
      .pc(pc), .if_id_inst(if_id_inst), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memWord(input logic [31:0] a);
      if (a == 32'd0) return 32'h2001_0005;
      if (a == 32'd4) return 32'h2002_0003;
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   assign imem_rdata = imem_rdy ? memWord(imem_addr) : 32'hDEAD_BEEF;

   // One clock: drive inputs, sample the request side, advance the model, land 1ns after the edge.
   task automatic cycle(input logic r, input logic st, input logic fl, input logic rd,
                        input logic [1:0] src, input logic [31:0] br, input logic [31:0] j);
      logic redir;
      logic [31:0] tgt;
      logic [63:0] w;
      @(negedge clk);
      {rst, stall, flush, imem_rdy, pc_src, pcBr, pcJ} = {r, st, fl, rd, src, br, j};
      #1;
      sawReq = imem_req;
      sawAddr = imem_addr;
      expReq = !r && skidQ.size() == 0;
      expAddr = mPc;
      redir = !st && src != 2'b00;
      tgt = src == 2'b01 ? br : j;
      if (r) begin
         mPc = 32'd0;
         skidQ.delete();
         pendQ.delete();
         {mInst, mPc4, mValid} = {32'd0, 32'd0, 1'b0};
      end else if (skidQ.size() != 0) begin
         if (!st) begin
            w = skidQ.pop_front();
            if (redir) begin
               {mInst, mPc4, mValid} = {32'd0, 32'd0, 1'b0};
               mPc = tgt;
            end else begin
               {mInst, mPc4, mValid} = {w, 1'b1};
               mPc = w[31:0];
            end
         end
      end else if (rd) begin
         if (pendQ.size() != 0) begin
            mPc = pendQ.pop_front();
            if (!st) {mInst, mPc4, mValid} = {32'd0, 32'd0, 1'b0};
         end else if (st) skidQ.push_back({memWord(mPc), mPc + 32'd4});
         else if (redir) begin
            {mInst, mPc4, mValid} = {32'd0, 32'd0, 1'b0};
            mPc = tgt;
         end else begin
            {mInst, mPc4, mValid} = {memWord(mPc), mPc + 32'd4, 1'b1};
            mPc = mPc + 32'd4;
         end
      end else if (!st) begin
         {mInst, mPc4, mValid} = {32'd0, 32'd0, 1'b0};
         if (redir) begin
            pendQ.delete();
            pendQ.push_back(tgt);
         end
      end
      if (fl) {mInst, mPc4, mValid} = {32'd0, 32'd0, 1'b0};
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      for (int i = 0; i < 2; i++) begin
         cycle(1, 0, 0, 1, 2'b00, 0, 0);
         checks++;
         if (sawReq !== 1'b0 || if_id_valid !== 1'b0 || pc !== 32'd0) begin
            errors++;
            $display("FAIL reset req=%b valid=%b pc=%h want 0 0 00000000", sawReq, if_id_valid, pc);
         end
      end
   endtask

   task automatic test_sequential;
      logic [31:0] wantInst[2] = '{32'h2001_0005, 32'h2002_0003};
      for (int i = 0; i < 2; i++) begin
         cycle(0, 0, 0, 1, 2'b00, 0, 0);
         checks++;
         if (pc !== 32'd4 * (i + 1) || if_id_inst !== wantInst[i] || if_id_pc4 !== 32'd4 * (i + 1) || if_id_valid !== 1'b1) begin
            errors++;
            $display("FAIL seq%0d pc=%h inst=%h pc4=%h v=%b want pc=%h inst=%h", i, pc, if_id_inst, if_id_pc4, if_id_valid, 32'd4 * (i + 1), wantInst[i]);
         end
      end
   endtask

   task automatic test_branch;
      cycle(0, 0, 0, 1, 2'b01, 32'h40, 32'h999);
      checks++;
      if (pc !== 32'h40 || if_id_valid !== 1'b0 || if_id_inst !== 32'd0) begin
         errors++;
         $display("FAIL branch_bubble pc=%h v=%b inst=%h want 00000040 0 00000000", pc, if_id_valid, if_id_inst);
      end
      cycle(0, 0, 0, 1, 2'b00, 0, 0);
      checks++;
      if (if_id_inst !== memWord(32'h40) || if_id_pc4 !== 32'h44 || if_id_valid !== 1'b1 || pc !== 32'h44) begin
         errors++;
         $display("FAIL branch_target inst=%h pc4=%h v=%b pc=%h want %h 00000044 1 00000044", if_id_inst, if_id_pc4, if_id_valid, pc, memWord(32'h40));
      end
   endtask

   task automatic test_stall_skid;
      cycle(0, 0, 0, 1, 2'b10, 0, 32'h0C);
      cycle(0, 0, 0, 1, 2'b00, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cycle(0, 1, 0, 1, 2'b01, 32'h777, 0);
         checks++;
         if (pc !== 32'h10 || if_id_inst !== memWord(32'h0C) || if_id_pc4 !== 32'h10 || if_id_valid !== 1'b1
             || (i > 0 && sawReq !== 1'b0)) begin
            errors++;
            $display("FAIL stall%0d pc=%h inst=%h pc4=%h v=%b req=%b want 00000010 %h 00000010 1", i, pc, if_id_inst, if_id_pc4, if_id_valid, sawReq, memWord(32'h0C));
         end
      end
      cycle(0, 0, 0, 1, 2'b00, 0, 0);
      checks++;
      if (if_id_inst !== memWord(32'h10) || if_id_pc4 !== 32'h14 || if_id_valid !== 1'b1 || pc !== 32'h14) begin
         errors++;
         $display("FAIL skid_release inst=%h pc4=%h v=%b pc=%h want %h 00000014 1 00000014", if_id_inst, if_id_pc4, if_id_valid, pc, memWord(32'h10));
      end
   endtask

   task automatic test_redirect_wait;
      cycle(0, 0, 0, 1, 2'b10, 0, 32'h20);
      for (int i = 0; i < 3; i++) begin
         cycle(0, 0, 0, 0, i == 0 ? 2'b10 : 2'b00, 0, 32'h100);
         checks++;
         if (sawAddr !== 32'h20 || sawReq !== 1'b1 || pc !== 32'h20 || if_id_valid !== 1'b0) begin
            errors++;
            $display("FAIL wait%0d addr=%h req=%b pc=%h v=%b want 00000020 1 00000020 0", i, sawAddr, sawReq, pc, if_id_valid);
         end
      end
      cycle(0, 0, 0, 1, 2'b00, 0, 0);
      checks++;
      if (sawAddr !== 32'h20 || pc !== 32'h100 || if_id_valid !== 1'b0) begin
         errors++;
         $display("FAIL wait_rdy addr=%h pc=%h v=%b want 00000020 00000100 0", sawAddr, pc, if_id_valid);
      end
      cycle(0, 0, 0, 1, 2'b00, 0, 0);
      checks++;
      if (if_id_inst !== memWord(32'h100) || if_id_pc4 !== 32'h104 || if_id_valid !== 1'b1) begin
         errors++;
         $display("FAIL wait_target inst=%h pc4=%h v=%b want %h 00000104 1", if_id_inst, if_id_pc4, if_id_valid, memWord(32'h100));
      end
   endtask

   task automatic test_flush_stall;
      cycle(0, 1, 1, 1, 2'b00, 0, 0);
      checks++;
      if (if_id_valid !== 1'b0 || if_id_inst !== 32'd0 || if_id_pc4 !== 32'd0 || pc !== 32'h104) begin
         errors++;
         $display("FAIL flush_stall v=%b inst=%h pc4=%h pc=%h want 0 00000000 00000000 00000104", if_id_valid, if_id_inst, if_id_pc4, pc);
      end
      cycle(0, 0, 0, 1, 2'b00, 0, 0);
      checks++;
      if (if_id_inst !== memWord(32'h104) || if_id_pc4 !== 32'h108 || if_id_valid !== 1'b1 || pc !== 32'h108) begin
         errors++;
         $display("FAIL flush_release inst=%h pc4=%h v=%b pc=%h want %h 00000108 1 00000108", if_id_inst, if_id_pc4, if_id_valid, pc, memWord(32'h104));
      end
   endtask

   task automatic test_wrap_reset;
      cycle(0, 0, 0, 1, 2'b11, 0, 32'hFFFF_FFFC);
      cycle(0, 0, 0, 1, 2'b00, 0, 0);
      checks++;
      if (if_id_pc4 !== 32'd0 || pc !== 32'd0 || if_id_inst !== memWord(32'hFFFF_FFFC) || if_id_valid !== 1'b1) begin
         errors++;
         $display("FAIL wrap pc4=%h pc=%h inst=%h v=%b want 00000000 00000000 %h 1", if_id_pc4, pc, if_id_inst, if_id_valid, memWord(32'hFFFF_FFFC));
      end
      cycle(0, 0, 0, 0, 2'b01, 32'h300, 0);
      cycle(1, 0, 0, 0, 2'b00, 0, 0);
      checks++;
      if (pc !== 32'd0 || if_id_valid !== 1'b0 || sawReq !== 1'b0) begin
         errors++;
         $display("FAIL midfetch_reset pc=%h v=%b req=%b want 00000000 0 0", pc, if_id_valid, sawReq);
      end
      cycle(0, 0, 0, 1, 2'b00, 0, 0);
      checks++;
      if (pc !== 32'd4 || if_id_inst !== 32'h2001_0005 || if_id_valid !== 1'b1) begin
         errors++;
         $display("FAIL pend_cleared pc=%h inst=%h v=%b want 00000004 20010005 1", pc, if_id_inst, if_id_valid);
      end
   endtask

   task automatic test_random;
      logic [1:0] src;
      for (int i = 0; i < 600; i++) begin
         src = $urandom_range(0, 5) == 0 ? 2'($urandom_range(1, 3)) : 2'b00;
         cycle($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
               $urandom_range(0, 2) != 0, src, {$urandom_range(0, 16383), 2'b00}, {$urandom, 2'b00});
         checks++;
         if (sawReq !== expReq || sawAddr !== expAddr || pc !== mPc || if_id_inst !== mInst
             || if_id_pc4 !== mPc4 || if_id_valid !== mValid) begin
            errors++;
            $display("FAIL rand%0d req=%b addr=%h pc=%h inst=%h pc4=%h v=%b want %b %h %h %h %h %b", i,
                     sawReq, sawAddr, pc, if_id_inst, if_id_pc4, if_id_valid, expReq, expAddr, mPc, mInst, mPc4, mValid);
         end
      end
   endtask

   initial begin
      test_reset;
      test_sequential;
      test_branch;
      test_stall_skid;
      test_redirect_wait;
      test_flush_stall;
      test_wrap_reset;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
